seg_display_ctrl: RTL and testbench

- Parametrised multiplexed 7-segment display peripheral on the PicoSoC iomem bus.
- Replaces the fixed 4-digit scan logic with:
  - configurable digit count and scan/second dividers;
  - software-visible data/control/status registers;
  - per-digit blanking, 16-level brightness PWM, blink and colon modes.
- Sits beside the GPIO peripheral; drives COMM, SEG and COLON directly.

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/seg_display_ctrl_hex_to_seg7.sv | 22 ++
 rtl/seg_display_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment display peripheral:
// register offsets, CTRL/STATUS bit positions, the upright and upside-down
// hexadecimal glyph tables (bit 6 = g .. bit 0 = a, 1 = segment on) and a
// byte-strobe merge helper used by the register file.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [7:0] OFS_DATA   = 8'h00;
  localparam logic [7:0] OFS_CTRL   = 8'h04;
  localparam logic [7:0] OFS_STATUS = 8'h08;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_BLINK      = 1;
  localparam int CTRL_CFORCE     = 2;
  localparam int CTRL_CVAL       = 3;
  localparam int CTRL_BRIGHT_LSB = 8;
  localparam int CTRL_BLANK_LSB  = 16;

  localparam int STAT_TOGGLE = 0;
  localparam int STAT_STICKY = 1;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] GLYPH_UP = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Display mounted rotated 180 degrees: a<->d, b<->e, c<->f, g unchanged.
  localparam logic [15:0][6:0] GLYPH_FLIP = {
    7'h4E, 7'h4F, 7'h73, 7'h0F, 7'h67, 7'h7E, 7'h7D, 7'h7F,
    7'h38, 7'h6F, 7'h6D, 7'h74, 7'h79, 7'h5B, 7'h30, 7'h3F
  };

  function automatic logic [31:0] apply_wstrb(input logic [31:0] i_old,
                                               input logic [31:0] i_new,
                                               input logic [3:0]  i_strb);
    logic [31:0] mask;
    mask = {{8{i_strb[3]}}, {8{i_strb[2]}}, {8{i_strb[1]}}, {8{i_strb[0]}}};
    return (i_old & ~mask) | (i_new & mask);
  endfunction

endpackage

// File: rtl/seg_display_ctrl_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to 7-segment glyph lookup (1 = segment on). Output
// polarity is applied by the instantiating block.
//   i_nibble : hexadecimal digit 0..F
//   o_glyph  : segments, bit 6 = g .. bit 0 = a
// Parameter SEG_FLIP selects the upside-down table when non-zero.
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg_pkg::*;
#(
  parameter int SEG_FLIP = 1
) (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = (SEG_FLIP != 0) ? GLYPH_FLIP[i_nibble] : GLYPH_UP[i_nibble];
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// Multiplexed 7-segment display peripheral on the PicoSoC iomem bus.
//   clk, reset            : system clock, synchronous active-high reset
//   iomem_valid/wstrb/addr/wdata : bus request (wstrb==0 is a read)
//   iomem_ready           : single-cycle acknowledge, one cycle after request
//   iomem_rdata           : read data, valid while iomem_ready is high
//   comm                  : one-hot digit commons (polarity by COMM_ACTIVE_LOW)
//   seg                   : segments g..a (polarity by SEG_ACTIVE_HIGH)
//   colon                 : colon LED, active high
//   second_tick           : one-cycle pulse on every second_toggle edge
// Registers: 0x00 DATA, 0x04 CTRL, 0x08 STATUS (toggle RO, sticky W1C).
// -----------------------------------------------------------------------------
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int         NUM_DIGITS      = 4,
  parameter logic [7:0] BASE_PAGE       = 8'h05,
  parameter int         SCAN_DIV        = 4096,
  parameter int         SEC_DIV         = 16000000,
  parameter int         COMM_ACTIVE_LOW = 1,
  parameter int         SEG_ACTIVE_HIGH = 1,
  parameter int         SEG_FLIP        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iomem_valid,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic                  iomem_ready,
  output logic [31:0]           iomem_rdata,
  output logic [NUM_DIGITS-1:0] comm,
  output logic [6:0]            seg,
  output logic                  colon,
  output logic                  second_tick
);

  localparam int DATA_BITS = NUM_DIGITS * 4;
  localparam logic [31:0] DATA_MASK = (DATA_BITS >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << DATA_BITS) - 32'd1);
  localparam logic [31:0] CTRL_MASK = (((32'd1 << NUM_DIGITS) - 32'd1) << CTRL_BLANK_LSB)
                                    | 32'h0000_0F0F;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SUB_MAX = SCAN_DIV / 16 - 1;
  localparam int SUB_W   = (SUB_MAX > 0) ? $clog2(SUB_MAX + 1) : 1;
  localparam int SEC_W   = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_MAX);
  localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(SEC_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] COMM_OFF = (COMM_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;

  // Bus-visible registers
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [31:0]           r_data;
  logic [31:0]           r_ctrl;
  logic                  r_sticky;
  // Second timer
  logic [SEC_W-1:0]      r_sec_cnt;
  logic                  r_toggle;
  logic                  r_tick;
  // Scan state; the slot counter is split into a PWM phase (top 4 bits)
  // and a sub-count so SCAN_DIV need not be a power of two.
  logic [SUB_W-1:0]      r_sub;
  logic [3:0]            r_phase;
  logic [IDX_W-1:0]      r_idx;
  logic [31:0]           r_sh_data;
  logic [31:0]           r_sh_ctrl;
  // Output registers
  logic [NUM_DIGITS-1:0] r_comm;
  logic [6:0]            r_seg;
  logic                  r_colon;

  logic                  w_sel;
  logic                  w_wr;
  logic                  w_rd;
  logic [7:0]            w_ofs;
  logic [31:0]           w_rd_mux;
  logic                  w_sticky_clr;
  logic                  w_sub_last;
  logic                  w_slot_wrap;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic [3:0]            w_nibble;
  logic [6:0]            w_glyph;
  logic                  w_en;
  logic                  w_lit;
  logic                  w_unused;

  assign w_sel = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_PAGE);
  assign w_wr  = w_sel && (iomem_wstrb != 4'd0);
  assign w_rd  = w_sel && (iomem_wstrb == 4'd0);
  assign w_ofs = iomem_addr[7:0];

  assign w_sticky_clr = w_wr && (w_ofs == OFS_STATUS) && iomem_wstrb[0]
                        && iomem_wdata[STAT_STICKY];

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_ofs)
      OFS_DATA:   w_rd_mux = r_data;
      OFS_CTRL:   w_rd_mux = r_ctrl;
      OFS_STATUS: w_rd_mux = {30'd0, r_sticky, r_toggle};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  assign w_sub_last  = (r_sub == SUB_LAST);
  assign w_slot_wrap = w_sub_last && (r_phase == 4'hF);

  always_comb begin
    w_onehot = '0;
    w_nibble = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_onehot[i] = (r_idx == IDX_W'(i));
      if (r_idx == IDX_W'(i)) w_nibble = r_sh_data[4*i +: 4];
    end
  end

  hex_to_seg7 #(.SEG_FLIP(SEG_FLIP)) u_hex (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  assign w_blank_mask = r_sh_ctrl[CTRL_BLANK_LSB +: NUM_DIGITS];
  assign w_en         = r_sh_ctrl[CTRL_EN];
  // Blink darkens the display during the low half of second_toggle, which
  // is deliberately taken live rather than from the shadow copy.
  assign w_lit = w_en
              && !(|(w_blank_mask & w_onehot))
              && (r_phase <= r_sh_ctrl[CTRL_BRIGHT_LSB +: 4])
              && !(r_sh_ctrl[CTRL_BLINK] && !r_toggle);

  assign w_unused = ^{iomem_addr[23:8], r_sh_ctrl, r_sh_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= 32'd0;
      r_data    <= 32'd0;
      r_ctrl    <= 32'd0;
      r_sticky  <= 1'b0;
      r_sec_cnt <= SEC_LOAD;
      r_toggle  <= 1'b1;
      r_tick    <= 1'b0;
      r_sub     <= '0;
      r_phase   <= 4'd0;
      r_idx     <= IDX_LAST;
      r_sh_data <= 32'd0;
      r_sh_ctrl <= 32'd0;
      r_comm    <= COMM_OFF;
      r_seg     <= SEG_OFF;
      r_colon   <= 1'b0;
    end else begin
      // Bus stage: acknowledge and read data one cycle after the request
      r_ready <= w_sel;
      r_rdata <= w_rd ? w_rd_mux : 32'd0;
      if (w_wr && (w_ofs == OFS_DATA))
        r_data <= apply_wstrb(r_data, iomem_wdata, iomem_wstrb) & DATA_MASK;
      if (w_wr && (w_ofs == OFS_CTRL))
        r_ctrl <= apply_wstrb(r_ctrl, iomem_wdata, iomem_wstrb) & CTRL_MASK;
      // A tick wins over a simultaneous clear
      if (r_tick)
        r_sticky <= 1'b1;
      else if (w_sticky_clr)
        r_sticky <= 1'b0;

      // Second timer stage
      if (r_sec_cnt == '0) begin
        r_sec_cnt <= SEC_LOAD;
        r_toggle  <= ~r_toggle;
        r_tick    <= 1'b1;
      end else begin
        r_sec_cnt <= r_sec_cnt - 1'b1;
        r_tick    <= 1'b0;
      end

      // Scan stage: software updates become visible only at a slot boundary
      if (w_sub_last) begin
        r_sub   <= '0;
        r_phase <= r_phase + 1'b1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
      if (w_slot_wrap) begin
        r_idx     <= (r_idx == '0) ? IDX_LAST : r_idx - 1'b1;
        r_sh_data <= r_data;
        r_sh_ctrl <= r_ctrl;
      end

      // Output stage: comm and seg registered together so they switch on
      // the same edge
      r_comm  <= w_lit ? ((COMM_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot) : COMM_OFF;
      r_seg   <= w_lit ? ((SEG_ACTIVE_HIGH != 0) ? w_glyph : ~w_glyph) : SEG_OFF;
      r_colon <= w_en && (r_sh_ctrl[CTRL_CFORCE] ? r_sh_ctrl[CTRL_CVAL] : r_toggle);
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign comm        = r_comm;
  assign seg         = r_seg;
  assign colon       = r_colon;
  assign second_tick = r_tick;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_display_ctrl
// Self-checking bench for seg_display_ctrl (4 digits, SCAN_DIV=16, SEC_DIV=10).
// A reference model derives every expected output from the number of clock
// edges since reset plus the software-visible register contents.
// -----------------------------------------------------------------------------
module tb_seg_display_ctrl;

  localparam int ND   = 4;
  localparam int SCAN = 16;
  localparam int SEC  = 10;
  localparam bit FLIP = 1'b1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iomem_valid = 1'b0;
  logic [3:0]    iomem_wstrb = 4'd0;
  logic [31:0]   iomem_addr = 32'd0;
  logic [31:0]   iomem_wdata = 32'd0;
  logic          iomem_ready;
  logic [31:0]   iomem_rdata;
  logic [ND-1:0] comm;
  logic [6:0]    seg;
  logic          colon;
  logic          second_tick;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .NUM_DIGITS(ND), .BASE_PAGE(8'h05), .SCAN_DIV(SCAN), .SEC_DIV(SEC),
    .COMM_ACTIVE_LOW(1), .SEG_ACTIVE_HIGH(1), .SEG_FLIP(1)
  ) dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_ready(iomem_ready),
    .iomem_rdata(iomem_rdata), .comm(comm), .seg(seg), .colon(colon),
    .second_tick(second_tick)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            k;
  logic [31:0]   m_data, m_ctrl, m_sh_data, m_sh_ctrl, m_rdata;
  bit            m_sticky, m_ready, m_tick, m_colon;
  logic [ND-1:0] m_comm;
  logic [6:0]    m_seg;

  string up_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] g;
    string s;
    int p;
    g = 7'h00;
    s = up_segs[n];
    for (int i = 0; i < s.len(); i++) begin
      p = int'(s[i]) - 97;
      if (FLIP) p = (p < 3) ? p + 3 : ((p < 6) ? p - 3 : 6);
      g[p] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    int d, ph;
    bit tog, en, lit, sel, clr;
    logic [31:0] od, oc;
    if (reset) begin
      k = 0; m_data = 0; m_ctrl = 0; m_sh_data = 0; m_sh_ctrl = 0;
      m_sticky = 0; m_ready = 0; m_rdata = 0; m_tick = 0;
      m_comm = '1; m_seg = 7'h00; m_colon = 0;
      return;
    end
    tog = ((k / SEC) % 2) == 0;
    d   = ND - 1 - ((k / SCAN) % ND);
    ph  = (k % SCAN) / (SCAN / 16);
    en  = m_sh_ctrl[0];
    lit = en && !m_sh_ctrl[16 + d] && (ph <= int'(m_sh_ctrl[11:8]))
          && !(m_sh_ctrl[1] && !tog);
    m_comm  = lit ? ~(ND'(1) << d) : '1;
    m_seg   = lit ? glyph(int'(m_sh_data[4*d +: 4])) : 7'h00;
    m_colon = en && (m_sh_ctrl[2] ? m_sh_ctrl[3] : tog);
    sel = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h05);
    od = m_data;
    oc = m_ctrl;
    m_rdata = 32'd0;
    if (sel && iomem_wstrb == 4'd0) begin
      case (iomem_addr[7:0])
        8'h00:   m_rdata = m_data;
        8'h04:   m_rdata = m_ctrl;
        8'h08:   m_rdata = {30'd0, m_sticky, tog};
        default: m_rdata = 32'd0;
      endcase
    end
    clr = 0;
    if (sel && iomem_wstrb != 4'd0) begin
      case (iomem_addr[7:0])
        8'h00:   m_data = merge(m_data, iomem_wdata, iomem_wstrb) & 32'h0000_FFFF;
        8'h04:   m_ctrl = merge(m_ctrl, iomem_wdata, iomem_wstrb) & 32'h000F_0F0F;
        8'h08:   clr = iomem_wstrb[0] && iomem_wdata[1];
        default: ;
      endcase
    end
    if (m_tick) m_sticky = 1;
    else if (clr) m_sticky = 0;
    if ((k % SCAN) == SCAN - 1) begin
      m_sh_data = od;
      m_sh_ctrl = oc;
    end
    m_ready = sel;
    k++;
    m_tick = (k % SEC) == 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("ready", 32'(iomem_ready), 32'(m_ready));
    chk("rdata", iomem_rdata, m_rdata);
    chk("comm", 32'(comm), 32'(m_comm));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("colon", 32'(colon), 32'(m_colon));
    chk("tick", 32'(second_tick), 32'(m_tick));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input bit wr, input logic [7:0] ofs, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd);
    iomem_valid = 1'b1;
    iomem_addr  = {8'h05, 16'h0000, ofs};
    iomem_wdata = wd;
    iomem_wstrb = wr ? st : 4'd0;
    step();
    rd = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    step();
  endtask

  task automatic wait_comm(input logic [ND-1:0] pat, input int budget);
    int n;
    n = 0;
    while (comm !== pat && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (comm !== pat) begin
      failures++;
      $display("FAIL wait_comm timeout: actual=%b expected=%b", comm, pat);
    end
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    while (second_tick !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (second_tick !== 1'b1) begin
      failures++;
      $display("FAIL wait_tick timeout: actual=%b expected=1", second_tick);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  ofs;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp;
  } rv_t;

  typedef struct {
    logic [ND-1:0] c;
    logic [6:0]    s;
  } gv_t;

  rv_t rtab [20];
  gv_t gtab [4];

  initial begin
    logic [31:0] rd;
    int cnt [ND];
    int n;

    rtab = '{
      '{0, 8'h00, 32'h0, 4'h0, 32'h0000_0000},
      '{0, 8'h04, 32'h0, 4'h0, 32'h0000_0000},
      '{0, 8'h08, 32'h0, 4'h0, 32'h0000_0001},
      '{1, 8'h00, 32'h0000_1234, 4'hF, 32'h0},
      '{0, 8'h00, 32'h0, 4'h0, 32'h0000_1234},
      '{1, 8'h00, 32'h0000_AB00, 4'h2, 32'h0},
      '{0, 8'h00, 32'h0, 4'h0, 32'h0000_AB34},
      '{1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0},
      '{0, 8'h00, 32'h0, 4'h0, 32'h0000_FFFF},
      '{1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0},
      '{0, 8'h04, 32'h0, 4'h0, 32'h000F_0F0F},
      '{1, 8'h04, 32'h0, 4'hF, 32'h0},
      '{1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0},
      '{0, 8'h0C, 32'h0, 4'h0, 32'h0000_0000},
      '{1, 8'h04, 32'h1234_5678, 4'h1, 32'h0},
      '{0, 8'h04, 32'h0, 4'h0, 32'h0000_0008},
      '{1, 8'h00, 32'h0000_1234, 4'hF, 32'h0},
      '{1, 8'h04, 32'h0000_0F01, 4'hF, 32'h0},
      '{0, 8'h04, 32'h0, 4'h0, 32'h0000_0F01},
      '{0, 8'h00, 32'h0, 4'h0, 32'h0000_1234}
    };
    // Digit 3 shows nibble 1, digit 0 shows nibble 4 (upside-down glyphs)
    gtab = '{'{4'b0111, 7'h30}, '{4'b1011, 7'h5B}, '{4'b1101, 7'h79}, '{4'b1110, 7'h74}};

    reset = 1'b1;
    steps(3);
    chk("reset_comm", 32'(comm), 32'h0000_000F);
    chk("reset_seg", 32'(seg), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus(rtab[i].wr, rtab[i].ofs, rtab[i].wd, rtab[i].st, rd);
      if (!rtab[i].wr) chk($sformatf("reg_tab[%0d]", i), rd, rtab[i].exp);
    end

    // Request outside the page is ignored
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0000;
    step();
    chk("offpage_ready", 32'(iomem_ready), 32'h0);
    iomem_valid = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      wait_comm(gtab[i].c, 80);
      chk($sformatf("glyph_tab[%0d]", i), 32'(seg), 32'(gtab[i].s));
    end

    // Brightness 3: 4 lit cycles per 16-cycle slot
    bus(1, 8'h04, 32'h0000_0301, 4'hF, rd);
    steps(32);
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      for (int d = 0; d < ND; d++) if (comm[d] == 1'b0) cnt[d]++;
    end
    for (int d = 0; d < ND; d++) chk($sformatf("bright3_d%0d", d), 32'(cnt[d]), 32'd4);

    // Blank digits 0 and 2
    bus(1, 8'h04, 32'h0005_0F01, 4'hF, rd);
    steps(32);
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      for (int d = 0; d < ND; d++) if (comm[d] == 1'b0) cnt[d]++;
    end
    chk("blank_d0", 32'(cnt[0]), 32'd0);
    chk("blank_d1", 32'(cnt[1]), 32'd16);
    chk("blank_d2", 32'(cnt[2]), 32'd0);
    chk("blank_d3", 32'(cnt[3]), 32'd16);

    // Blink: dark during half of every 20-cycle toggle period
    bus(1, 8'h04, 32'h0000_0F03, 4'hF, rd);
    steps(32);
    n = 0;
    cnt[0] = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (comm != 4'hF) n++;
      if (second_tick) cnt[0]++;
    end
    chk("blink_lit", 32'(n), 32'd20);
    chk("tick_count", 32'(cnt[0]), 32'd4);
    bus(0, 8'h08, 32'h0, 4'h0, rd);
    chk("sticky_set", 32'(rd[1]), 32'd1);

    // Clear away from a tick
    wait_tick(20);
    steps(2);
    bus(1, 8'h08, 32'h0000_0002, 4'hF, rd);
    bus(0, 8'h08, 32'h0, 4'h0, rd);
    chk("sticky_clr", 32'(rd[1]), 32'd0);

    // Clear colliding with a tick keeps it set
    wait_tick(20);
    bus(1, 8'h08, 32'h0000_0002, 4'hF, rd);
    bus(0, 8'h08, 32'h0, 4'h0, rd);
    chk("sticky_collide", 32'(rd[1]), 32'd1);

    // Colon forced off, then following second_toggle
    bus(1, 8'h04, 32'h0000_0F05, 4'hF, rd);
    steps(32);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (colon) n++;
    end
    chk("colon_forced0", 32'(n), 32'd0);
    bus(1, 8'h04, 32'h0000_0F01, 4'hF, rd);
    steps(32);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (colon) n++;
    end
    chk("colon_toggle", 32'(n), 32'd20);

    // Mid-slot DATA change only shows from the next slot
    bus(1, 8'h00, 32'h0000_1234, 4'hF, rd);
    steps(40);
    wait_comm(4'b1110, 80);
    wait_comm(4'b0111, 80);
    steps(4);
    bus(1, 8'h00, 32'h0000_8888, 4'hF, rd);
    chk("midslot_comm", 32'(comm), 32'h7);
    chk("midslot_seg", 32'(seg), 32'h30);
    wait_comm(4'b1011, 40);
    chk("nextslot_seg", 32'(seg), 32'h7F);

    // Reset in the middle of a bus request and a lit slot
    steps(3);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0500_0000;
    iomem_wstrb = 4'd0;
    reset = 1'b1;
    step();
    chk("rst_ready", 32'(iomem_ready), 32'h0);
    chk("rst_comm", 32'(comm), 32'hF);
    chk("rst_seg", 32'(seg), 32'h0);
    reset = 1'b0;
    iomem_valid = 1'b0;
    step();
    chk("rst_no_pending", 32'(iomem_ready), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      iomem_valid = ($urandom_range(0, 2) != 0);
      iomem_addr  = {(($urandom_range(0, 7) == 0) ? 8'h06 : 8'h05), 16'h0000,
                     8'($urandom_range(0, 3) * 4)};
      iomem_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      iomem_wdata = $urandom;
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    iomem_valid = 1'b0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
